// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between trajectory and text clients plus a full-screen clear engine.
// Optional FB_ARB_VBLANK_SYNC_EN defers each clear to the next iVS falling edge.
module fb_write_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int NUM_PIX  = 307200,
  parameter int BG_INDEX = 0
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVS,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              trj_req,
  input  logic [ADDR_W-1:0] trj_addr,
  input  logic [DATA_W-1:0] trj_data,
  output logic              trj_ack,
  input  logic              txt_req,
  input  logic [ADDR_W-1:0] txt_addr,
  input  logic [DATA_W-1:0] txt_data,
  output logic              txt_ack,
  output logic              mem_wenable,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [DATA_W-1:0] C_BG        = DATA_W'(BG_INDEX);

`ifdef FB_ARB_VBLANK_SYNC_EN
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_trj_req, r_txt_req;
  logic              r_last_txt, w_last_txt_nxt;
  logic              w_busy_nxt, w_wen_nxt, w_trj_ack_nxt, w_txt_ack_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_serve, w_trj_elig, w_txt_elig, w_pick_trj, w_pick_txt;

`ifdef FB_ARB_VBLANK_SYNC_EN
  logic r_vs_prev;
  logic w_vs_fall;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) r_vs_prev <= 1'b0;
    else         r_vs_prev <= iVS;
  end

  assign w_vs_fall = r_vs_prev & ~iVS;
`else
  logic w_unused_vs;
  assign w_unused_vs = iVS;
`endif

  // Requests are registered first; a client whose ack is high is still
  // showing its old request in r_*_req, so it must not be re-granted.
  assign w_trj_elig = r_trj_req & ~trj_ack;
  assign w_txt_elig = r_txt_req & ~txt_ack;
  assign w_pick_trj = w_trj_elig & (r_last_txt | ~w_txt_elig);
  assign w_pick_txt = w_txt_elig & ~w_pick_trj;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_txt_nxt = r_last_txt;
    w_busy_nxt     = 1'b0;
    w_wen_nxt      = 1'b0;
    w_waddr_nxt    = '0;
    w_wdata_nxt    = '0;
    w_trj_ack_nxt  = 1'b0;
    w_txt_ack_nxt  = 1'b0;
    w_serve        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = '0;
`ifdef FB_ARB_VBLANK_SYNC_EN
          w_state_nxt = S_PEND;
`else
          w_state_nxt = S_CLEAR;
`endif
        end else begin
          w_serve = 1'b1;
        end
      end
`ifdef FB_ARB_VBLANK_SYNC_EN
      S_PEND: begin
        w_busy_nxt = 1'b1;
        if (w_vs_fall) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_serve = 1'b1;
        end
      end
`endif
      S_CLEAR: begin
        w_busy_nxt  = 1'b1;
        w_wen_nxt   = 1'b1;
        w_waddr_nxt = r_cnt;
        w_wdata_nxt = C_BG;
        if (r_cnt == C_LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_serve) begin
      if (w_pick_trj) begin
        w_wen_nxt      = 1'b1;
        w_waddr_nxt    = trj_addr;
        w_wdata_nxt    = trj_data;
        w_trj_ack_nxt  = 1'b1;
        w_last_txt_nxt = 1'b0;
      end else if (w_pick_txt) begin
        w_wen_nxt      = 1'b1;
        w_waddr_nxt    = txt_addr;
        w_wdata_nxt    = txt_data;
        w_txt_ack_nxt  = 1'b1;
        w_last_txt_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_trj_req   <= 1'b0;
      r_txt_req   <= 1'b0;
      r_last_txt  <= 1'b1;
      clr_busy    <= 1'b0;
      trj_ack     <= 1'b0;
      txt_ack     <= 1'b0;
      mem_wenable <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_trj_req   <= trj_req;
      r_txt_req   <= txt_req;
      r_last_txt  <= w_last_txt_nxt;
      clr_busy    <= w_busy_nxt;
      trj_ack     <= w_trj_ack_nxt;
      txt_ack     <= w_txt_ack_nxt;
      mem_wenable <= w_wen_nxt;
      mem_waddr   <= w_waddr_nxt;
      mem_wdata   <= w_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter (NUM_PIX=16, BG_INDEX=3); handshake timing and clear sequencing
// are predicted from the protocol rules, with random client traffic.
module tb_fb_write_arbiter;

  localparam int         NP = 16;
  localparam logic [2:0] BG = 3'd3;
`ifdef FB_ARB_VBLANK_SYNC_EN
  localparam int VB = 1;
`else
  localparam int VB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        clr_req = 1'b0;
  logic        c_req [2];
  logic [18:0] c_addr[2];
  logic [2:0]  c_data[2];
  logic        clr_busy, trj_ack, txt_ack, mem_wenable;
  logic [18:0] mem_waddr;
  logic [2:0]  mem_wdata;

  int errors = 0;
  int checks = 0;

  fb_write_arbiter #(.ADDR_W(19), .DATA_W(3), .NUM_PIX(NP), .BG_INDEX(3)) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iVS        (vs),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .trj_req    (c_req[0]),
    .trj_addr   (c_addr[0]),
    .trj_data   (c_data[0]),
    .trj_ack    (trj_ack),
    .txt_req    (c_req[1]),
    .txt_addr   (c_addr[1]),
    .txt_data   (c_data[1]),
    .txt_ack    (txt_ack),
    .mem_wenable(mem_wenable),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr_req = 1'b0; vs = 1'b1;
    for (int c = 0; c < 2; c++) begin
      c_req[c] = 1'b0; c_addr[c] = '0; c_data[c] = '0;
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_req = 1'b0; vs = 1'b1;
    c_req[0] = 1'b1; c_addr[0] = 19'h1234; c_data[0] = 3'd5;
    c_req[1] = 1'b0; c_addr[1] = '0;       c_data[1] = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_wenable !== 1'b0 || mem_waddr !== '0 || mem_wdata !== '0 ||
          trj_ack !== 1'b0 || txt_ack !== 1'b0 || clr_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: got wen=%b addr=%h data=%h tack=%b xack=%b busy=%b, want all 0",
                 i, mem_wenable, mem_waddr, mem_wdata, trj_ack, txt_ack, clr_busy);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (trj_ack !== 1'b0 || mem_wenable !== 1'b0) begin
      errors++;
      $display("FAIL reset_latency: got tack=%b wen=%b, want 0 0", trj_ack, mem_wenable);
    end
    tick();
    checks++;
    if (trj_ack !== 1'b1 || txt_ack !== 1'b0 || mem_wenable !== 1'b1 ||
        mem_waddr !== 19'h1234 || mem_wdata !== 3'd5) begin
      errors++;
      $display("FAIL reset_first_grant: got tack=%b xack=%b wen=%b addr=%h data=%0d, want 1 0 1 1234 5",
               trj_ack, txt_ack, mem_wenable, mem_waddr, mem_wdata);
    end
    c_req[0] = 1'b0;
    tick();
    checks++;
    if (trj_ack !== 1'b0 || mem_wenable !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack_pulse: got tack=%b wen=%b, want 0 0", trj_ack, mem_wenable);
    end
    tick();
  endtask

  // One client re-requesting immediately after each ack: a write every second cycle.
  task automatic test_single();
    logic exp_w;
    do_reset();
    c_req[1] = 1'b1; c_addr[1] = 19'($urandom); c_data[1] = 3'($urandom);
    for (int t = 1; t <= 12; t++) begin
      tick();
      exp_w = (t % 2 == 0);
      checks++;
      if (mem_wenable !== exp_w || txt_ack !== exp_w || trj_ack !== 1'b0 ||
          (exp_w && (mem_waddr !== c_addr[1] || mem_wdata !== c_data[1]))) begin
        errors++;
        $display("FAIL single t=%0d: got wen=%b xack=%b tack=%b addr=%h data=%0d, want wen=%b addr=%h data=%0d",
                 t, mem_wenable, txt_ack, trj_ack, mem_waddr, mem_wdata, exp_w, c_addr[1], c_data[1]);
      end
      if (exp_w) begin
        c_addr[1] = 19'($urandom); c_data[1] = 3'($urandom);
      end
    end
    c_req[1] = 1'b0;
    tick(); tick();
  endtask

  // Both clients always requesting: strict alternation, trj first after reset.
  task automatic test_round_robin();
    int turn;
    do_reset();
    c_req[0] = 1'b1; c_addr[0] = 19'd10; c_data[0] = 3'($urandom);
    c_req[1] = 1'b1; c_addr[1] = 19'd20; c_data[1] = 3'($urandom);
    turn = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      checks++;
      if (t == 1) begin
        if (mem_wenable !== 1'b0 || trj_ack !== 1'b0 || txt_ack !== 1'b0) begin
          errors++;
          $display("FAIL rr_first: got wen=%b tack=%b xack=%b, want 0 0 0", mem_wenable, trj_ack, txt_ack);
        end
      end else begin
        if (mem_wenable !== 1'b1 || trj_ack !== (turn == 0) || txt_ack !== (turn == 1) ||
            mem_waddr !== c_addr[turn] || mem_wdata !== c_data[turn]) begin
          errors++;
          $display("FAIL rr t=%0d: got wen=%b tack=%b xack=%b addr=%h data=%0d, want client %0d addr=%h data=%0d",
                   t, mem_wenable, trj_ack, txt_ack, mem_waddr, mem_wdata, turn, c_addr[turn], c_data[turn]);
        end
        c_data[turn] = 3'($urandom);
        if (t > 5) c_addr[turn] = 19'($urandom);
        turn = 1 - turn;
      end
    end
    c_req[0] = 1'b0; c_req[1] = 1'b0;
  endtask

  // Random traffic: each write belongs to exactly one acked client, carries its held
  // request, and arrives 2 or 3 cycles after the request is raised.
  task automatic test_random();
    int   lat[2];
    logic a;
    do_reset();
    lat[0] = 0; lat[1] = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      for (int c = 0; c < 2; c++) if (c_req[c]) lat[c]++;
      checks++;
      if ((trj_ack | txt_ack) !== mem_wenable || (trj_ack & txt_ack) === 1'b1) begin
        errors++;
        $display("FAIL rand_wen t=%0d: got wen=%b tack=%b xack=%b, want wen = one ack", t, mem_wenable, trj_ack, txt_ack);
      end
      for (int c = 0; c < 2; c++) begin
        a = (c == 0) ? trj_ack : txt_ack;
        if (a === 1'b1) begin
          checks++;
          if (!c_req[c] || mem_waddr !== c_addr[c] || mem_wdata !== c_data[c] || lat[c] < 2 || lat[c] > 3) begin
            errors++;
            $display("FAIL rand_grant t=%0d c=%0d: got addr=%h data=%0d lat=%0d, want addr=%h data=%0d lat 2..3 req=%b",
                     t, c, mem_waddr, mem_wdata, lat[c], c_addr[c], c_data[c], c_req[c]);
          end
          if ($urandom_range(1, 0) == 1) begin
            c_addr[c] = 19'($urandom); c_data[c] = 3'($urandom); lat[c] = 0;
          end else begin
            c_req[c] = 1'b0;
          end
        end else if (c_req[c] && lat[c] >= 3) begin
          checks++; errors++;
          $display("FAIL rand_timeout t=%0d c=%0d: got no ack after %0d cycles, want ack by 3", t, c, lat[c]);
          c_req[c] = 1'b0;
        end else if (!c_req[c] && $urandom_range(2, 0) == 0) begin
          c_req[c] = 1'b1; c_addr[c] = 19'($urandom); c_data[c] = 3'($urandom); lat[c] = 0;
        end
      end
    end
    c_req[0] = 1'b0; c_req[1] = 1'b0;
  endtask

  // trj pending on the clr_req edge loses to the clear and is granted right after it.
  task automatic test_clear();
    logic exp_wr, exp_busy, exp_ack;
    int   n_busy, n_wr;
    do_reset();
    c_req[0] = 1'b1; c_addr[0] = 19'($urandom); c_data[0] = 3'($urandom);
    tick();
    clr_req = 1'b1;
    n_busy = 0; n_wr = 0;
    for (int t = 1; t <= NP + 6; t++) begin
      tick();
      if (t == 1) begin
        clr_req = 1'b0;
        if (VB == 1) vs = 1'b0;
      end
      exp_wr   = (t >= 2 + VB) && (t <= NP + 1 + VB);
      exp_busy = (t <= NP + VB);
      exp_ack  = (t == NP + 2 + VB);
      checks++;
      if (clr_busy !== exp_busy) begin
        errors++;
        $display("FAIL clr_busy t=%0d: got %b want %b", t, clr_busy, exp_busy);
      end
      checks++;
      if (mem_wenable !== (exp_wr | exp_ack) || trj_ack !== exp_ack || txt_ack !== 1'b0) begin
        errors++;
        $display("FAIL clr_wen t=%0d: got wen=%b tack=%b xack=%b, want wen=%b tack=%b xack=0",
                 t, mem_wenable, trj_ack, txt_ack, exp_wr | exp_ack, exp_ack);
      end
      if (exp_wr) begin
        checks++;
        if (mem_waddr !== 19'(t - 2 - VB) || mem_wdata !== BG) begin
          errors++;
          $display("FAIL clr_write t=%0d: got addr=%0d data=%0d, want addr=%0d data=%0d", t, mem_waddr, mem_wdata, t - 2 - VB, BG);
        end
        if (mem_wenable === 1'b1) n_wr++;
      end
      if (exp_ack) begin
        checks++;
        if (mem_waddr !== c_addr[0] || mem_wdata !== c_data[0]) begin
          errors++;
          $display("FAIL clr_after_grant: got addr=%h data=%0d, want addr=%h data=%0d", mem_waddr, mem_wdata, c_addr[0], c_data[0]);
        end
        c_req[0] = 1'b0;
      end
      if (clr_busy === 1'b1) n_busy++;
    end
    checks++;
    if (n_busy != NP + VB || n_wr != NP) begin
      errors++;
      $display("FAIL clr_counts: got busy=%0d writes=%0d, want busy=%0d writes=%0d", n_busy, n_wr, NP + VB, NP);
    end
    vs = 1'b1;
    tick();
  endtask

  // txt arrives mid-clear and a second clr_req is issued mid-clear; neither disturbs the sweep.
  task automatic test_clear_holdoff();
    logic exp_wr, exp_ack;
    do_reset();
    clr_req = 1'b1;
    for (int t = 1; t <= NP + 6; t++) begin
      tick();
      if (t == 1 || t == 10 + VB) clr_req = 1'b0;
      if (t == 1 && VB == 1) vs = 1'b0;
      exp_wr  = (t >= 2 + VB) && (t <= NP + 1 + VB);
      exp_ack = (t == NP + 2 + VB);
      checks++;
      if (mem_wenable !== (exp_wr | exp_ack) || txt_ack !== exp_ack || trj_ack !== 1'b0 ||
          (exp_wr && mem_waddr !== 19'(t - 2 - VB)) ||
          (exp_ack && (mem_waddr !== c_addr[1] || mem_wdata !== c_data[1]))) begin
        errors++;
        $display("FAIL holdoff t=%0d: got wen=%b xack=%b tack=%b addr=%0d, want wen=%b xack=%b",
                 t, mem_wenable, txt_ack, trj_ack, mem_waddr, exp_wr | exp_ack, exp_ack);
      end
      if (exp_ack) c_req[1] = 1'b0;
      if (t == 6 + VB) begin
        c_req[1] = 1'b1; c_addr[1] = 19'($urandom); c_data[1] = 3'($urandom);
      end
      if (t == 9 + VB) clr_req = 1'b1;
    end
    vs = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clr_req = 1'b1;
    for (int t = 1; t <= 9 + VB; t++) begin
      tick();
      if (t == 1) begin
        clr_req = 1'b0;
        if (VB == 1) vs = 1'b0;
      end
    end
    checks++;
    if (mem_wenable !== 1'b1 || mem_waddr !== 19'd7) begin
      errors++;
      $display("FAIL rstmid_pre: got wen=%b addr=%0d, want 1 7", mem_wenable, mem_waddr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_wenable !== 1'b0 || mem_waddr !== '0 || mem_wdata !== '0 || clr_busy !== 1'b0 ||
        trj_ack !== 1'b0 || txt_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got wen=%b addr=%0d data=%0d busy=%b, want all 0", mem_wenable, mem_waddr, mem_wdata, clr_busy);
    end
    tick(); tick();
    rst_n = 1'b1; vs = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (mem_wenable !== 1'b0 || clr_busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet t=%0d: got wen=%b busy=%b addr=%0d, want 0 0", t, mem_wenable, clr_busy, mem_waddr);
      end
    end
  endtask

`ifdef FB_ARB_VBLANK_SYNC_EN
  task automatic test_vblank();
    logic exp_wr, exp_ack;
    do_reset();
    clr_req = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      tick();
      if (t == 1) clr_req = 1'b0;
      exp_wr  = (t >= 52) && (t <= 52 + NP - 1);
      exp_ack = (t == 7);
      checks++;
      if (clr_busy !== (t <= 51 + NP - 1) || mem_wenable !== (exp_wr | exp_ack) || trj_ack !== exp_ack ||
          (exp_wr && (mem_waddr !== 19'(t - 52) || mem_wdata !== BG)) ||
          (exp_ack && (mem_waddr !== c_addr[0] || mem_wdata !== c_data[0]))) begin
        errors++;
        $display("FAIL vblank t=%0d: got busy=%b wen=%b tack=%b addr=%0d data=%0d, want busy=%b wen=%b tack=%b",
                 t, clr_busy, mem_wenable, trj_ack, mem_waddr, mem_wdata, t <= 51 + NP - 1, exp_wr | exp_ack, exp_ack);
      end
      if (exp_ack) c_req[0] = 1'b0;
      if (t == 5) begin
        c_req[0] = 1'b1; c_addr[0] = 19'($urandom); c_data[0] = 3'($urandom);
      end
      if (t == 50) vs = 1'b0;
    end
    vs = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_clear();
    test_clear_holdoff();
    test_reset_mid_clear();
`ifdef FB_ARB_VBLANK_SYNC_EN
    test_vblank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
